instr_fetch_unit: RTL and testbench



---
 rtl/tpu_isa_pkg.sv | 26 ++
 rtl/byte_pair_assembler.sv | 38 +++
 rtl/instr_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_isa_pkg.sv
// rtl/tpu_isa_pkg.sv - TPU ISA opcodes, instruction field positions and fetch FSM state encodings
package tpu_isa_pkg;

  localparam int OPCODE_WIDTH = 3;
  localparam int ADDR_IND_BIT = 4;
  localparam int BOT_MEM_BIT  = 3;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    STORE_OP = 3'd0,
    FETCH_OP = 3'd1,
    RUN_OP   = 3'd2,
    LOAD_OP  = 3'd3,
    HALT_OP  = 3'd4,
    NOP      = 3'd5
  } opcode_e;

  typedef logic [2:0] fetch_state_e;

  localparam fetch_state_e S_I_LO    = 3'd0;
  localparam fetch_state_e S_I_HI    = 3'd1;
  localparam fetch_state_e S_A_LO    = 3'd2;
  localparam fetch_state_e S_A_HI    = 3'd3;
  localparam fetch_state_e S_PRESENT = 3'd4;
  localparam fetch_state_e S_HALTED  = 3'd5;

endpackage

// File: rtl/byte_pair_assembler.sv
// rtl/byte_pair_assembler.sv - holds the first byte of a pair and presents the little-endian word on the second
module byte_pair_assembler #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_clear,
  input  logic           i_capture,
  input  logic [W-1:0]   i_byte,
  output logic [2*W-1:0] o_word,
  output logic           o_done
);

  logic [W-1:0] r_lo;
  logic         r_half;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lo   <= '0;
      r_half <= 1'b0;
    end else if (i_clear) begin
      r_lo   <= '0;
      r_half <= 1'b0;
    end else if (i_capture) begin
      if (r_half) begin
        r_half <= 1'b0;
      end else begin
        r_lo   <= i_byte;
        r_half <= 1'b1;
      end
    end
  end

  // Word is valid combinationally during the capture of the high byte.
  assign o_word = {i_byte, r_lo};
  assign o_done = i_capture & r_half;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - rx FIFO byte popper and instruction/address word fetcher; FETCH_TIMEOUT_EN adds an inter-byte timeout
module instr_fetch_unit
  import tpu_isa_pkg::*;
#(
  parameter int FIFO_DATA_WIDTH  = 8,
  parameter int BUFFER_WORD_SIZE = 16,
  parameter int ADDRESS_SIZE     = 10,
  parameter int OPCODE_WIDTH     = 3,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fifo_empty,
  input  logic [FIFO_DATA_WIDTH-1:0]  fifo_rd_data,
  output logic                        fifo_re,
  output logic                        instr_valid,
  input  logic                        instr_ready,
  output logic [BUFFER_WORD_SIZE-1:0] instr,
  output logic [ADDRESS_SIZE-1:0]     operand,
  output logic                        operand_valid,
  output logic                        halted,
  output logic                        err_timeout
);

  if (BUFFER_WORD_SIZE != 2*FIFO_DATA_WIDTH || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("instr_fetch_unit: unsupported parameter combination");
  end

  fetch_state_e                r_state;
  logic [BUFFER_WORD_SIZE-1:0] r_instr;
  logic [ADDRESS_SIZE-1:0]     r_operand;
  logic                        r_instr_valid;
  logic                        r_operand_valid;
  logic                        r_halted;
  logic                        w_byte_state;
  logic                        w_asm_clear;
  logic [BUFFER_WORD_SIZE-1:0] w_word;
  logic                        w_done;

  assign w_byte_state = (r_state == S_I_LO) || (r_state == S_I_HI) ||
                        (r_state == S_A_LO) || (r_state == S_A_HI);
  assign fifo_re = ~fifo_empty & ~r_halted & ~rst & w_byte_state;

  byte_pair_assembler #(.W(FIFO_DATA_WIDTH)) u_bpa (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_asm_clear),
    .i_capture (fifo_re),
    .i_byte    (fifo_rd_data),
    .o_word    (w_word),
    .o_done    (w_done)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] r_tcnt;
  logic          r_err_timeout;
  logic          w_tmo_state;

  assign w_tmo_state = (r_state == S_I_HI) || (r_state == S_A_LO) || (r_state == S_A_HI);
  assign w_asm_clear = w_tmo_state & fifo_empty & (r_tcnt == TMO_LAST);
  assign err_timeout = r_err_timeout;
`else
  assign w_asm_clear = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_I_LO;
      r_instr         <= '0;
      r_operand       <= '0;
      r_instr_valid   <= 1'b0;
      r_operand_valid <= 1'b0;
      r_halted        <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      r_tcnt          <= '0;
      r_err_timeout   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_I_LO: if (fifo_re) begin
          r_instr[FIFO_DATA_WIDTH-1:0] <= fifo_rd_data;
          r_state                      <= S_I_HI;
        end
        S_I_HI: if (w_done) begin
          r_instr <= w_word;
          if (w_word[OPCODE_WIDTH-1:0] == STORE_OP && w_word[ADDR_IND_BIT]) begin
            r_state <= S_A_LO;
          end else begin
            r_operand       <= '0;
            r_operand_valid <= 1'b0;
            r_instr_valid   <= 1'b1;
            r_state         <= S_PRESENT;
          end
        end
        S_A_LO: if (fifo_re) r_state <= S_A_HI;
        S_A_HI: if (w_done) begin
          r_operand       <= w_word[ADDRESS_SIZE-1:0];
          r_operand_valid <= 1'b1;
          r_instr_valid   <= 1'b1;
          r_state         <= S_PRESENT;
        end
        S_PRESENT: if (r_instr_valid && instr_ready) begin
          r_instr_valid <= 1'b0;
          if (r_instr[OPCODE_WIDTH-1:0] == HALT_OP) begin
            r_halted <= 1'b1;
            r_state  <= S_HALTED;
          end else begin
            r_state <= S_I_LO;
          end
        end
        default: r_state <= r_state;
      endcase
`ifdef FETCH_TIMEOUT_EN
      // No pop and no state change can happen while the FIFO is empty, so this only clears otherwise.
      r_err_timeout <= 1'b0;
      if (w_tmo_state && fifo_empty) begin
        if (r_tcnt == TMO_LAST) begin
          r_tcnt        <= '0;
          r_err_timeout <= 1'b1;
          r_instr       <= '0;
          r_state       <= S_I_LO;
        end else begin
          r_tcnt <= r_tcnt + 1'b1;
        end
      end else begin
        r_tcnt <= '0;
      end
`endif
    end
  end

  assign instr         = r_instr;
  assign operand       = r_operand;
  assign instr_valid   = r_instr_valid;
  assign operand_valid = r_operand_valid;
  assign halted        = r_halted;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit with a queue-backed rx FIFO model
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic [7:0]  fifo_rd_data;
  logic        fifo_re;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [9:0]  operand;
  logic        operand_valid;
  logic        halted;
  logic        err_timeout;

  logic [7:0]  fq[$];
  logic [26:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          pop_cnt = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .FIFO_DATA_WIDTH (8),
    .BUFFER_WORD_SIZE(16),
    .ADDRESS_SIZE    (10),
    .OPCODE_WIDTH    (3),
    .TIMEOUT_CYCLES  (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_re      (fifo_re),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .operand      (operand),
    .operand_valid(operand_valid),
    .halted       (halted),
    .err_timeout  (err_timeout)
  );

  always_comb begin
    fifo_empty   = 1'b1;
    fifo_rd_data = 8'h00;
    if (fq.size() > 0) begin
      fifo_empty   = 1'b0;
      fifo_rd_data = fq[0];
    end
  end

  always @(posedge clk) begin
    if (fifo_re) begin
      #1;
      if (fq.size() > 0) void'(fq.pop_front());
      pop_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every accepted word is compared against the oldest expectation.
  always @(negedge clk) begin
    if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {5'd0, instr, operand, operand_valid}, 32'hFFFF_FFFF);
      end else begin
        logic [26:0] e;
        e = exp_q.pop_front();
        chk("sb_instr", {16'd0, instr}, {16'd0, e[26:11]});
        chk("sb_operand", {22'd0, operand}, {22'd0, e[10:1]});
        chk("sb_operand_valid", {31'd0, operand_valid}, {31'd0, e[0]});
      end
    end
  end

  task automatic drive_step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
  endtask

  task automatic expect_word(input logic [15:0] i, input logic [9:0] op, input logic ov);
    exp_q.push_back({i, op, ov});
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  task automatic pulse_reset();
    drive_step();
    rst = 1'b1;
    drive_step();
    drive_step();
    rst = 1'b0;
  endtask

  initial begin
    int base;
    int k;
    logic prev_valid;
    logic stable_ok;

    rst = 1'b1;
    instr_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_instr_valid", {31'd0, instr_valid}, 0);
    chk("rst_instr", {16'd0, instr}, 0);
    chk("rst_operand", {22'd0, operand}, 0);
    chk("rst_halted", {31'd0, halted}, 0);
    chk("rst_err_timeout", {31'd0, err_timeout}, 0);
    drive_step();
    rst = 1'b0;

    // Plain NOP word, ready held high.
    base = pop_cnt;
    instr_ready = 1'b1;
    expect_word(16'h8005, 10'h000, 1'b0);
    push(8'h05); push(8'h80);
    k = 0;
    while (instr_valid !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    chk("t1_valid_seen", {31'd0, instr_valid}, 1);
    @(negedge clk);
    chk("t1_valid_one_cycle", {31'd0, instr_valid}, 0);
    wait_drain("t1_drain");
    chk("t1_pops", pop_cnt - base, 2);

    // STORE with address indicator fetches a trailing address word.
    base = pop_cnt;
    expect_word(16'h0010, 10'h123, 1'b1);
    push(8'h10); push(8'h00); push(8'h23); push(8'h01);
    prev_valid = 1'b0;
    k = 0;
    while (pop_cnt < base + 4 && k < 50) begin
      prev_valid = instr_valid;
      @(negedge clk);
      k++;
    end
    chk("t2_valid_before_last_pop", {31'd0, prev_valid}, 0);
    chk("t2_valid_after_last_pop", {31'd0, instr_valid}, 1);
    wait_drain("t2_drain");

    // Back-pressure: word held stable, no pops until transfer.
    drive_step();
    instr_ready = 1'b0;
    base = pop_cnt;
    expect_word(16'h4002, 10'h000, 1'b0);
    expect_word(16'h0001, 10'h000, 1'b0);
    push(8'h02); push(8'h40); push(8'h01);
    k = 0;
    while (instr_valid !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    stable_ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (instr !== 16'h4002 || instr_valid !== 1'b1 || fifo_re !== 1'b0) stable_ok = 1'b0;
      @(negedge clk);
    end
    chk("t3_hold_stable", {31'd0, stable_ok}, 1);
    chk("t3_pops_while_held", pop_cnt - base, 2);
    drive_step();
    instr_ready = 1'b1;
    push(8'h00);
    wait_drain("t3_drain");
    chk("t3_pops_total", pop_cnt - base, 4);

    // HALT stops fetching until reset.
    expect_word(16'h0004, 10'h000, 1'b0);
    expect_word(16'h0005, 10'h000, 1'b0);
    push(8'h04); push(8'h00); push(8'h05); push(8'h00);
    k = 0;
    while (halted !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    chk("t4_halted", {31'd0, halted}, 1);
    base = pop_cnt;
    stable_ok = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (fifo_re !== 1'b0 || fifo_empty !== 1'b0) stable_ok = 1'b0;
      @(negedge clk);
    end
    chk("t4_no_pop_when_halted", {31'd0, stable_ok}, 1);
    chk("t4_pop_count_frozen", pop_cnt - base, 0);
    pulse_reset();
    @(negedge clk);
    chk("t4_halted_cleared", {31'd0, halted}, 0);
    wait_drain("t4_drain");

    // Reset mid-word discards the partial byte.
    base = pop_cnt;
    expect_word(16'h0001, 10'h000, 1'b0);
    push(8'h03);
    repeat (3) drive_step();
    chk("t5_partial_popped", pop_cnt - base, 1);
    rst = 1'b1;
    drive_step();
    rst = 1'b0;
    push(8'h01); push(8'h00);
    wait_drain("t5_drain");

`ifdef FETCH_TIMEOUT_EN
    base = pop_cnt;
    push(8'h03);
    k = 0;
    while (pop_cnt < base + 1 && k < 50) begin @(negedge clk); k++; end
    k = 0;
    while (err_timeout !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    chk("t6_timeout_delay", k, 8);
    @(negedge clk);
    chk("t6_timeout_pulse_width", {31'd0, err_timeout}, 0);
    expect_word(16'h0002, 10'h000, 1'b0);
    push(8'h02); push(8'h00);
    wait_drain("t6_drain");
`endif

    chk("final_sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
